// File: rtl/graph_pkg.sv
// Shared constants and types for the graph calculator video path.
package graph_pkg;
  localparam int H_ORG  = 400;
  localparam int V_ORG  = 240;
  localparam int POS_W  = 12;
  localparam int COEF_W = 8;
  localparam int C_W    = 12;
  localparam int XY_W   = 13;
  localparam int F_W    = 32;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [C_W-1:0]    coef_c_t;
  typedef logic signed [XY_W-1:0]   xy_t;
  typedef logic signed [F_W-1:0]    f_t;
  typedef logic [23:0]              rgb_t;

  localparam rgb_t BG    = 24'hCCCCCC;
  localparam rgb_t AXIS  = 24'h000000;
  localparam rgb_t CURVE = 24'h00CC00;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } side_t;
endpackage

// File: rtl/poly_eval.sv
// Three-stage evaluation of f = (a*x^2 + b*x) >>> FRAC_BITS + c.
module poly_eval
  import graph_pkg::*;
#(
  parameter int FRAC_BITS = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  xy_t     x,
  input  coef_t   a,
  input  coef_t   b,
  input  coef_c_t c,
  output f_t      f
);
  logic [18:0]        xsq;
  logic signed [20:0] bx;
  logic signed [31:0] sum;

  logic signed [25:0] xe, x2;
  logic signed [20:0] be, xb, bx_w;
  logic signed [27:0] ae, xq, ax2;

  // Operands are widened to the product width; only the low bits are kept,
  // which are identical for signed and unsigned multiplies.
  always_comb begin
    xe   = {{13{x[12]}}, x};
    x2   = xe * xe;
    be   = {{13{b[7]}}, b};
    xb   = {{8{x[12]}}, x};
    bx_w = be * xb;
    ae   = {{20{a[7]}}, a};
    xq   = {9'b0, xsq};
    ax2  = ae * xq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xsq <= '0;
      bx  <= '0;
      sum <= '0;
      f   <= '0;
    end else begin
      xsq <= x2[18:0];
      bx  <= bx_w;
      sum <= {{4{ax2[27]}}, ax2} + {{11{bx[20]}}, bx};
      f   <= (sum >>> FRAC_BITS) + {{20{c[11]}}, c};
    end
  end
endmodule

// File: rtl/curve_plotter.sv
// Pixel colour stage: background, axes and a quadratic curve, 5-clk latency.
module curve_plotter
  import graph_pkg::*;
#(
  parameter int H_ORG           = graph_pkg::H_ORG,
  parameter int V_ORG           = graph_pkg::V_ORG,
  parameter int FRAC_BITS       = 4,
  parameter int THICK           = 1,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  coef_t             coef_a,
  input  coef_t             coef_b,
  input  coef_c_t           coef_c,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out
);
  localparam int    STAGES   = 5;
  localparam logic  SYNC_OFF = SYNC_ACTIVE_LOW;
  localparam side_t SIDE_RST = '{de: 1'b0, hs: SYNC_OFF, vs: SYNC_OFF};

  coef_t   a_s, b_s;
  coef_c_t c_s;
  logic    vs_q;
  side_t   sb_pipe [1:STAGES];
  xy_t     x_pipe [1:STAGES-1];
  xy_t     y_pipe [1:STAGES-1];
  f_t      f, fprev, lo, hi, yw;
  rgb_t    rgb_q;
  logic    vs_on, first, curve, axis;

  assign vs_on = (vsync_in != SYNC_OFF);

  poly_eval #(.FRAC_BITS(FRAC_BITS)) u_poly (
    .clk(clk), .reset(reset), .x(x_pipe[1]),
    .a(a_s), .b(b_s), .c(c_s), .f(f)
  );

  // sb_pipe[5] holds the previous S4 pixel, so its de marks the line start.
  always_comb begin
    first = sb_pipe[4].de && !sb_pipe[STAGES].de;
    lo    = (first || f < fprev) ? f : fprev;
    hi    = (first || f > fprev) ? f : fprev;
    yw    = {{19{y_pipe[4][12]}}, y_pipe[4]};
    curve = (yw >= lo - f_t'(THICK)) && (yw <= hi + f_t'(THICK));
    axis  = (x_pipe[4] == '0) || (y_pipe[4] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_s   <= '0;
      b_s   <= '0;
      c_s   <= '0;
      vs_q  <= 1'b0;
      fprev <= '0;
      rgb_q <= '0;
      for (int i = 1; i <= STAGES; i++) sb_pipe[i] <= SIDE_RST;
      for (int i = 1; i < STAGES; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
    end else begin
      vs_q <= vs_on;
      if (vs_on && !vs_q) begin
        a_s <= coef_a;
        b_s <= coef_b;
        c_s <= coef_c;
      end
      x_pipe[1]  <= xy_t'({1'b0, hpos}) - xy_t'(H_ORG);
      y_pipe[1]  <= xy_t'(V_ORG) - xy_t'({1'b0, vpos});
      sb_pipe[1] <= '{de: de_in, hs: hsync_in, vs: vsync_in};
      for (int i = 2; i <= STAGES; i++) sb_pipe[i] <= sb_pipe[i-1];
      for (int i = 2; i < STAGES; i++) begin
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
      end
      if (sb_pipe[4].de) fprev <= f;
      if (!sb_pipe[4].de) rgb_q <= '0;
      else if (curve)     rgb_q <= CURVE;
      else if (axis)      rgb_q <= AXIS;
      else                rgb_q <= BG;
    end
  end

  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign de_out    = sb_pipe[STAGES].de;
  assign hsync_out = sb_pipe[STAGES].hs;
  assign vsync_out = sb_pipe[STAGES].vs;
endmodule

// File: tb/tb_curve_plotter.sv
// Directed bench for curve_plotter: colours, latency, fprev line break, coefficient shadowing.
module tb_curve_plotter;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] hpos, vpos;
  logic        de_in, hsync_in, vsync_in;
  logic [7:0]  coef_a, coef_b;
  logic [11:0] coef_c;
  logic [7:0]  red, green, blue;
  logic        de_out, hsync_out, vsync_out;

  localparam logic [23:0] GREY = 24'hCCCCCC;
  localparam logic [23:0] BLK  = 24'h000000;
  localparam logic [23:0] GRN  = 24'h00CC00;

  int n_cmp = 0;
  int n_bad = 0;

  curve_plotter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .red(red), .green(green), .blue(blue),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input int h, input int v, input logic d, input logic hs, input logic vs);
    @(negedge clk);
    hpos = 12'(h); vpos = 12'(v); de_in = d; hsync_in = hs; vsync_in = vs;
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  // Drive one pixel, then idle; early = {de,hs} after 4 edges, late/rgb after 5.
  task automatic probe(input int h, input int v, input logic d, input logic hs,
                       output logic [23:0] rgb, output logic [1:0] early, output logic [1:0] late);
    drive(h, v, d, hs, 1'b1);
    repeat (4) idle();
    early = {de_out, hsync_out};
    @(negedge clk);
    rgb  = {red, green, blue};
    late = {de_out, hsync_out};
  endtask

  task automatic load_coef(input int a, input int b, input int c);
    coef_a = 8'(a); coef_b = 8'(b); coef_c = 12'(c);
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    coef_a = '0; coef_b = '0; coef_c = '0;
    drive(400, 240, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({red, green, blue, de_out, hsync_out, vsync_out} !== {24'h0, 3'b011}) begin
      n_bad++;
      $display("FAIL reset_state: got rgb=%h de/hs/vs=%b%b%b want rgb=000000 de/hs/vs=011",
               {red, green, blue}, de_out, hsync_out, vsync_out);
    end
    reset = 1'b0;
    idle();
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    repeat (4) idle();
    n_cmp++;
    if (vsync_out !== 1'b1) begin
      n_bad++; $display("FAIL vsync_early: got %b want 1", vsync_out);
    end
    @(negedge clk);
    n_cmp++;
    if (vsync_out !== 1'b0) begin
      n_bad++; $display("FAIL vsync_at_5: got %b want 0", vsync_out);
    end
    @(negedge clk);
    n_cmp++;
    if (vsync_out !== 1'b1) begin
      n_bad++; $display("FAIL vsync_after: got %b want 1", vsync_out);
    end
  endtask

  task automatic test_axes();
    int h[3]; int v[3]; logic [23:0] exp_c[3];
    logic [23:0] rgb; logic [1:0] e, l;
    h = '{400, 400, 10}; v = '{240, 100, 10}; exp_c = '{GRN, BLK, GREY};
    for (int i = 0; i < 3; i++) begin
      probe(h[i], v[i], 1'b1, 1'b1, rgb, e, l);
      n_cmp++;
      if (rgb !== exp_c[i] || e[1] !== 1'b0 || l[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL axes_%0d: got rgb=%h de@4=%b de@5=%b want rgb=%h de@4=0 de@5=1",
                 i, rgb, e[1], l[1], exp_c[i]);
      end
    end
  endtask

  task automatic test_parabola();
    int v[3]; logic [23:0] exp_c[3];
    logic [23:0] rgb; logic [1:0] e, l;
    load_coef(16, 0, 0);
    v = '{140, 160, 138}; exp_c = '{GRN, GRN, GREY};
    for (int i = 0; i < 3; i++) begin
      for (int hh = 400; hh < 410; hh++) drive(hh, v[i], 1'b1, 1'b1, 1'b1);
      probe(410, v[i], 1'b1, 1'b1, rgb, e, l);
      n_cmp++;
      if (rgb !== exp_c[i]) begin
        n_bad++;
        $display("FAIL parabola_v%0d: got rgb=%h want %h", v[i], rgb, exp_c[i]);
      end
    end
  endtask

  task automatic test_line_break();
    logic [23:0] rgb; logic [1:0] e, l;
    load_coef(0, 16, 0);
    for (int hh = 0; hh < 800; hh++) drive(hh, 100, 1'b1, 1'b1, 1'b1);
    repeat (8) idle();
    probe(0, 100, 1'b1, 1'b1, rgb, e, l);
    n_cmp++;
    if (rgb !== GREY) begin
      n_bad++; $display("FAIL line_start_fprev: got rgb=%h want %h", rgb, GREY);
    end
    drive(449, 190, 1'b1, 1'b1, 1'b1);
    probe(450, 190, 1'b1, 1'b1, rgb, e, l);
    n_cmp++;
    if (rgb !== GRN) begin
      n_bad++; $display("FAIL line_on_curve: got rgb=%h want %h", rgb, GRN);
    end
  endtask

  task automatic test_midframe();
    logic [23:0] rgb; logic [1:0] e, l;
    load_coef(0, 0, 0);
    coef_a = 8'd16;
    drive(409, 140, 1'b1, 1'b1, 1'b1);
    probe(410, 140, 1'b1, 1'b1, rgb, e, l);
    n_cmp++;
    if (rgb !== GREY) begin
      n_bad++; $display("FAIL midframe_held: got rgb=%h want %h", rgb, GREY);
    end
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) idle();
    drive(409, 140, 1'b1, 1'b1, 1'b1);
    probe(410, 140, 1'b1, 1'b1, rgb, e, l);
    n_cmp++;
    if (rgb !== GRN) begin
      n_bad++; $display("FAIL midframe_next: got rgb=%h want %h", rgb, GRN);
    end
  endtask

  task automatic test_de_gate();
    logic [23:0] rgb; logic [1:0] e, l;
    drive(409, 140, 1'b0, 1'b1, 1'b1);
    probe(410, 140, 1'b0, 1'b0, rgb, e, l);
    n_cmp++;
    if (rgb !== 24'h0 || l !== 2'b00 || e !== 2'b01) begin
      n_bad++;
      $display("FAIL de_gate: got rgb=%h de/hs@4=%b de/hs@5=%b want rgb=000000 @4=01 @5=00",
               rgb, e, l);
    end
  endtask

  task automatic test_reset_midframe();
    drive(400, 240, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (de_out !== 1'b0 || {red, green, blue} !== 24'h0) begin
      n_bad++; $display("FAIL reset_mid_hold: got de=%b rgb=%h want 0/000000", de_out, {red, green, blue});
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (de_out !== (k >= 5)) begin
        n_bad++; $display("FAIL reset_release_%0d: got de=%b want %b", k, de_out, k >= 5);
      end
    end
    n_cmp++;
    if ({red, green, blue} !== GRN) begin
      n_bad++; $display("FAIL reset_release_rgb: got %h want %h", {red, green, blue}, GRN);
    end
    idle();
  endtask

  initial begin
    hpos = '0; vpos = '0; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    test_reset();
    test_axes();
    test_parabola();
    test_line_break();
    test_midframe();
    test_de_gate();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
